// File: rtl/mult_pkg.sv
// Shared types for the MultDiv multiplier path.
// Widths, FSM states and radix-4 Booth select codes.
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 16;
  localparam int ACC_W = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_P1,
    SEL_P2,
    SEL_M1,
    SEL_M2
  } sel_e;

  function automatic sel_e booth_sel(input logic [2:0] t);
    sel_e s;
    case (t)
      3'b001, 3'b010: s = SEL_P1;
      3'b011:         s = SEL_P2;
      3'b100:         s = SEL_M2;
      3'b101, 3'b110: s = SEL_M1;
      default:        s = SEL_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/add34_cla.sv
// 34-bit adder: four 8-bit lookahead slices
// plus a 2-bit ripple top for bits [33:32].
module bit8_cla (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       gout,
  output logic       pout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;
  logic       gg;

  assign g    = a & b;
  assign p    = a ^ b;
  assign pout = &p;
  assign gout = gg;
  assign sum  = p ^ c;

  // in-slice carries and group generate
  always_comb begin
    c    = '0;
    gg   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 7; i++)
      c[i+1] = g[i] | (p[i] & c[i]);
    for (int i = 0; i < 8; i++)
      gg = g[i] | (p[i] & gg);
  end

endmodule

module add34_cla (
  input  logic [33:0] a,
  input  logic [33:0] b,
  input  logic        cin,
  output logic [33:0] sum
);

  logic [3:0] gs;
  logic [3:0] ps;
  logic [4:0] cs;
  logic       c33;

  for (genvar k = 0; k < 4; k++) begin : g_slice
    bit8_cla u_s (
      .a    (a[8*k +: 8]),
      .b    (b[8*k +: 8]),
      .cin  (cs[k]),
      .sum  (sum[8*k +: 8]),
      .gout (gs[k]),
      .pout (ps[k])
    );
  end

  // slice-to-slice carries from group g/p
  always_comb begin
    cs    = '0;
    cs[0] = cin;
    for (int k = 0; k < 4; k++)
      cs[k+1] = gs[k] | (ps[k] & cs[k]);
  end

  assign sum[32] = a[32] ^ b[32] ^ cs[4];
  assign c33     = (a[32] & b[32])
                 | (cs[4] & (a[32] ^ b[32]));
  assign sum[33] = a[33] ^ b[33] ^ c33;

endmodule

// File: rtl/mult_booth_r4.sv
// Iterative signed 32x32 radix-4 Booth multiplier.
// Low product word, overflow flag, one-cycle ready.
module mult_booth_r4
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int ITER  = mult_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e           state;
  logic [4:0]       count;
  logic [ACC_W-1:0] mcand;
  logic [ACC_W-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             qm1;
  logic [WIDTH-1:0] res_q;
  logic             exc_q;

  sel_e             sel;
  logic [ACC_W-1:0] mag;
  logic             neg;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             exc_n;

  assign sel = booth_sel({lo[1:0], qm1});

  // partial product magnitude and sign
  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (sel)
      SEL_P1: mag = mcand;
      SEL_P2: mag = mcand << 1;
      SEL_M1: begin
        mag = mcand;
        neg = 1'b1;
      end
      SEL_M2: begin
        mag = mcand << 1;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
  end

  assign addend = neg ? ~mag : mag;

  add34_cla u_add (
    .a   (hi),
    .b   (addend),
    .cin (neg),
    .sum (sum)
  );

  assign hi_n  = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
  assign lo_n  = {sum[1:0], lo[WIDTH-1:2]};
  assign exc_n = hi_n[WIDTH-1:0] != {WIDTH{lo_n[WIDTH-1]}};

  // start, iterate, and latch result on last step
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      qm1   <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else if (ctrl_MULT) begin
      state <= RUN;
      count <= '0;
      mcand <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
      hi    <= '0;
      lo    <= data_operandB;
      qm1   <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          hi    <= hi_n;
          lo    <= lo_n;
          qm1   <= lo[1];
          count <= count + 5'd1;
          if (count == 5'(ITER - 1)) begin
            state <= DONE;
            res_q <= lo_n;
            exc_q <= exc_n;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_mult_booth_r4.sv
// Randomised and directed bench for mult_booth_r4.
// Latency-level model checked every cycle.
module tb_mult_booth_r4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ctrl = 1'b0;
  logic [31:0] res;
  logic        exc;
  logic        rdy;

  logic        lit_on = 1'b0;
  logic [31:0] lit_res = '0;
  logic        lit_exc = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mult_booth_r4 dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  always #5 clock = ~clock;

  // model state: product appears 16 edges after the last start
  logic        m_act = 1'b0;
  int          m_age = 0;
  int          m_a = 0;
  int          m_b = 0;
  logic [31:0] e_res = '0;
  logic        e_exc = 1'b0;
  logic        e_rdy = 1'b0;
  logic        c_lit = 1'b0;
  logic [31:0] c_res = '0;
  logic        c_exc = 1'b0;

  function automatic void check(string nm, logic [31:0] got,
                                logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endfunction

  // model update on each edge, then compare after it
  always @(posedge clock) begin
    longint p;
    if (!reset_n) begin
      m_act = 1'b0;
      e_res = '0;
      e_exc = 1'b0;
      e_rdy = 1'b0;
    end else begin
      e_rdy = 1'b0;
      if (ctrl) begin
        m_act = 1'b1;
        m_age = 0;
        m_a   = int'(op_a);
        m_b   = int'(op_b);
        c_lit = lit_on;
        c_res = lit_res;
        c_exc = lit_exc;
        e_res = '0;
        e_exc = 1'b0;
      end else if (m_act) begin
        m_age++;
        if (m_age == 16) begin
          p     = longint'(m_a) * longint'(m_b);
          e_res = p[31:0];
          e_exc = p[63:32] != {32{p[31]}};
          e_rdy = 1'b1;
          m_act = 1'b0;
        end
      end
    end
    #1;
    check("rdy", 32'(rdy), 32'(e_rdy));
    check("result", res, e_res);
    check("exception", 32'(exc), 32'(e_exc));
    if (e_rdy && c_lit) begin
      check("lit_result", res, c_res);
      check("lit_exception", 32'(exc), 32'(c_exc));
      c_lit = 1'b0;
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic lit, input logic [31:0] lr,
                       input logic le);
    @(negedge clock);
    op_a    = a;
    op_b    = b;
    ctrl    = 1'b1;
    lit_on  = lit;
    lit_res = lr;
    lit_exc = le;
    @(negedge clock);
    ctrl    = 1'b0;
    lit_on  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [31:0] edge_v [8];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    edge_v[0] = 32'h8000_0000;
    edge_v[1] = 32'h7FFF_FFFF;
    edge_v[2] = 32'hFFFF_FFFF;
    edge_v[3] = 32'h0000_0000;
    edge_v[4] = 32'h0000_0001;
    edge_v[5] = 32'h0001_0000;
    edge_v[6] = 32'h0000_8000;
    edge_v[7] = 32'h5555_5555;

    idle(3);
    reset_n = 1'b1;
    idle(2);

    start(32'd3, 32'd5, 1'b1, 32'd15, 1'b0);
    idle(18);
    start(32'hFFFF_FFF9, 32'd6, 1'b1, 32'hFFFF_FFD6, 1'b0);
    idle(18);
    start(32'd6, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFD6, 1'b0);
    idle(18);
    start(32'h7FFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b1);
    idle(18);
    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    idle(18);
    start(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 1'b1);
    idle(18);
    start(32'h0001_0000, 32'h0000_8000, 1'b1, 32'h8000_0000, 1'b1);
    idle(18);
    start(32'h0, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    idle(18);

    // restart at E5 discards the first product
    start(32'd10, 32'd10, 1'b0, 32'd0, 1'b0);
    idle(3);
    start(32'd4, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFF4, 1'b0);
    idle(20);

    // restart on the ready cycle
    start(32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
    idle(15);
    start(32'd7, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFF9, 1'b0);
    idle(18);

    // reset in the middle of a run
    start(32'd123, 32'd456, 1'b0, 32'd0, 1'b0);
    idle(6);
    @(negedge clock);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(20);
    start(32'd100, 32'hFFFF_FF9C, 1'b1, 32'hFFFF_D8F0, 1'b0);
    idle(18);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = edge_v[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) rb = edge_v[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0) rb = rb >>> $urandom_range(0, 31);
      start(ra, rb, 1'b0, 32'd0, 1'b0);
      idle($urandom_range(0, 4) == 0 ? $urandom_range(0, 16)
                                     : $urandom_range(17, 20));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
